// File: rtl/fir_accumulate.sv
// rtl/fir_accumulate.sv - sums NUM_TAPS signed products into one saturated FIR output sample
module fir_accumulate #(
    parameter int DATA_SIZE = 32,
    parameter int NUM_TAPS  = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    output logic                        in_rd_en,
    input  logic                        in_empty,
    input  logic signed [DATA_SIZE-1:0] din,
    output logic                        out_wr_en,
    input  logic                        out_full,
    output logic signed [DATA_SIZE-1:0] dout,
    output logic                        sat
);

    // The accumulator carries enough headroom that NUM_TAPS full-scale
    // products can never wrap; clamping happens only on the final sum.
    localparam int CNT_W    = $clog2(NUM_TAPS);
    localparam int ACC_SIZE = DATA_SIZE + CNT_W + 1;

    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NUM_TAPS - 1);

    localparam logic signed [ACC_SIZE-1:0] MAX_V =
        {{(ACC_SIZE - DATA_SIZE + 1){1'b0}}, {(DATA_SIZE - 1){1'b1}}};
    localparam logic signed [ACC_SIZE-1:0] MIN_V =
        {{(ACC_SIZE - DATA_SIZE + 1){1'b1}}, {(DATA_SIZE - 1){1'b0}}};

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_WRITE = 2'd1
    } state_t;

    state_t                       state_q, state_d;
    logic signed [ACC_SIZE-1:0]   acc_q, acc_d;
    logic        [CNT_W-1:0]      count_q, count_d;
    logic signed [DATA_SIZE-1:0]  result_q, result_d;
    logic                         sat_q, sat_d;

    logic signed [ACC_SIZE-1:0]   din_ext;
    logic signed [ACC_SIZE-1:0]   sum;
    logic signed [DATA_SIZE-1:0]  clamped;
    logic                         clipped;
    logic                         rd_req;
    logic                         wr_req;

    // Sign-extend the incoming product and form the running sum.
    always_comb begin
        din_ext = {{(ACC_SIZE - DATA_SIZE){din[DATA_SIZE-1]}}, din};
        sum     = acc_q + din_ext;
    end

    // Saturate the wide sum into the output sample range.
    always_comb begin
        clamped = sum[DATA_SIZE-1:0];
        clipped = 1'b0;
        if (sum > MAX_V) begin
            clamped = MAX_V[DATA_SIZE-1:0];
            clipped = 1'b1;
        end else if (sum < MIN_V) begin
            clamped = MIN_V[DATA_SIZE-1:0];
            clipped = 1'b1;
        end
    end

    // Next-state and FIFO handshake decode.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        count_d  = count_q;
        result_d = result_q;
        sat_d    = sat_q;
        rd_req   = 1'b0;
        wr_req   = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                if (!in_empty) begin
                    rd_req = 1'b1;
                    if (count_q == LAST_TAP) begin
                        result_d = clamped;
                        sat_d    = clipped;
                        acc_d    = '0;
                        count_d  = '0;
                        state_d  = ST_WRITE;
                    end else begin
                        acc_d   = sum;
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            ST_WRITE: begin
                // Products waiting in the input FIFO are left alone until
                // the finished sample has been pushed.
                if (!out_full) begin
                    wr_req  = 1'b1;
                    state_d = ST_ACCUM;
                end
            end
            default: begin
                acc_d   = '0;
                count_d = '0;
                state_d = ST_ACCUM;
            end
        endcase
    end

    // Handshakes are masked by reset so nothing is popped or pushed while it is held.
    always_comb begin
        in_rd_en  = reset & rd_req;
        out_wr_en = reset & wr_req;
        dout      = result_q;
        sat       = sat_q;
    end

    // State register with asynchronous clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_ACCUM;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            result_q <= result_d;
            sat_q    <= sat_d;
        end
    end

endmodule

// File: tb/tb_fir_accumulate.sv
// tb/tb_fir_accumulate.sv - directed checks of fir_accumulate with NUM_TAPS=4
module tb_fir_accumulate;

    logic        clock;
    logic        reset;
    logic        in_rd_en;
    logic        in_empty;
    logic [31:0] din;
    logic        out_wr_en;
    logic        out_full;
    logic [31:0] dout;
    logic        sat;

    int vectors;
    int miscompares;
    int wr_cnt;
    int exp_wr_cnt;

    fir_accumulate #(.DATA_SIZE(32), .NUM_TAPS(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_rd_en  (in_rd_en),
        .in_empty  (in_empty),
        .din       (din),
        .out_wr_en (out_wr_en),
        .out_full  (out_full),
        .dout      (dout),
        .sat       (sat)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (out_wr_en === 1'b1) wr_cnt <= wr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive FIFO flags at the falling edge, check handshakes.
    task automatic cyc(input string tag, input logic e, input logic [31:0] d, input logic f,
                       input logic exp_rd, input logic exp_wr);
        @(negedge clock);
        in_empty = e;
        din      = d;
        out_full = f;
        #1;
        chk({tag, "_rd"}, {31'd0, in_rd_en}, {31'd0, exp_rd});
        chk({tag, "_wr"}, {31'd0, out_wr_en}, {31'd0, exp_wr});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        wr_cnt      = 0;
        exp_wr_cnt  = 0;
        reset       = 1'b0;
        in_empty    = 1'b0;
        din         = 32'd5;
        out_full    = 1'b0;
        #1;
        chk("rst_rd",   {31'd0, in_rd_en},  32'd0);
        chk("rst_wr",   {31'd0, out_wr_en}, 32'd0);
        chk("rst_dout", dout,               32'd0);
        chk("rst_sat",  {31'd0, sat},       32'd0);
        @(negedge clock);
        in_empty = 1'b1;
        @(negedge clock);
        reset = 1'b1;

        // 1,2,3,4 back-to-back
        cyc("t1_r0", 1'b0, 32'd1, 1'b0, 1'b1, 1'b0);
        cyc("t1_r1", 1'b0, 32'd2, 1'b0, 1'b1, 1'b0);
        cyc("t1_r2", 1'b0, 32'd3, 1'b0, 1'b1, 1'b0);
        cyc("t1_r3", 1'b0, 32'd4, 1'b0, 1'b1, 1'b0);
        cyc("t1_w",  1'b1, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("t1_dout", dout, 32'd10);
        chk("t1_sat",  {31'd0, sat}, 32'd0);
        exp_wr_cnt++;
        cyc("t1_idle", 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("t1_wrcnt", wr_cnt, exp_wr_cnt);

        // -5,3,-7,2
        cyc("t2_r0", 1'b0, 32'hFFFFFFFB, 1'b0, 1'b1, 1'b0);
        cyc("t2_r1", 1'b0, 32'd3,        1'b0, 1'b1, 1'b0);
        cyc("t2_r2", 1'b0, 32'hFFFFFFF9, 1'b0, 1'b1, 1'b0);
        cyc("t2_r3", 1'b0, 32'd2,        1'b0, 1'b1, 1'b0);
        cyc("t2_w",  1'b1, 32'd0,        1'b0, 1'b0, 1'b1);
        chk("t2_dout", dout, 32'hFFFFFFF9);
        chk("t2_sat",  {31'd0, sat}, 32'd0);
        exp_wr_cnt++;

        // positive saturation
        for (int i = 0; i < 4; i++) cyc("t3_r", 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
        cyc("t3_w", 1'b1, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("t3_dout", dout, 32'h7FFFFFFF);
        chk("t3_sat",  {31'd0, sat}, 32'd1);
        exp_wr_cnt++;

        // negative saturation
        for (int i = 0; i < 4; i++) cyc("t4_r", 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        cyc("t4_w", 1'b1, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("t4_dout", dout, 32'h80000000);
        chk("t4_sat",  {31'd0, sat}, 32'd1);
        exp_wr_cnt++;

        // sat clears on an in-range sum
        for (int i = 0; i < 4; i++) cyc("t5_r", 1'b0, 32'd1, 1'b0, 1'b1, 1'b0);
        cyc("t5_w", 1'b1, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("t5_dout", dout, 32'd4);
        chk("t5_sat",  {31'd0, sat}, 32'd0);
        exp_wr_cnt++;

        // backpressure: products remain available while the output is full
        cyc("t6_r0", 1'b0, 32'd10, 1'b0, 1'b1, 1'b0);
        cyc("t6_r1", 1'b0, 32'd20, 1'b0, 1'b1, 1'b0);
        cyc("t6_r2", 1'b0, 32'd30, 1'b0, 1'b1, 1'b0);
        cyc("t6_r3", 1'b0, 32'd40, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc("t6_full", 1'b0, 32'd5, 1'b1, 1'b0, 1'b0);
            chk("t6_hold", dout, 32'd100);
        end
        cyc("t6_w", 1'b0, 32'd5, 1'b0, 1'b0, 1'b1);
        chk("t6_dout", dout, 32'd100);
        exp_wr_cnt++;
        for (int i = 0; i < 4; i++) cyc("t6_next", 1'b0, 32'd5, 1'b0, 1'b1, 1'b0);
        cyc("t6_w2", 1'b1, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("t6_dout2", dout, 32'd20);
        exp_wr_cnt++;
        cyc("t6_idle", 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("t6_wrcnt", wr_cnt, exp_wr_cnt);

        // starvation: three empty cycles before each product
        for (int p = 1; p <= 4; p++) begin
            for (int g = 0; g < 3; g++) cyc("t7_gap", 1'b1, 32'd99, 1'b0, 1'b0, 1'b0);
            cyc("t7_r", 1'b0, p, 1'b0, 1'b1, 1'b0);
        end
        chk("t7_nowr", wr_cnt, exp_wr_cnt);
        cyc("t7_w", 1'b1, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("t7_dout", dout, 32'd10);
        exp_wr_cnt++;

        // asynchronous reset in the middle of a block
        cyc("t8_r0", 1'b0, 32'd7, 1'b0, 1'b1, 1'b0);
        cyc("t8_r1", 1'b0, 32'd7, 1'b0, 1'b1, 1'b0);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("t8_rst_rd",   {31'd0, in_rd_en},  32'd0);
        chk("t8_rst_wr",   {31'd0, out_wr_en}, 32'd0);
        chk("t8_rst_dout", dout,               32'd0);
        chk("t8_rst_sat",  {31'd0, sat},       32'd0);
        in_empty = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) cyc("t8_r", 1'b0, 32'd1, 1'b0, 1'b1, 1'b0);
        cyc("t8_w", 1'b1, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("t8_dout", dout, 32'd4);
        exp_wr_cnt++;
        cyc("t8_idle", 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("t8_wrcnt", wr_cnt, exp_wr_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
